// File: rtl/my_struct_package.sv
// Shared types for the trace reader, cache controller and cache storage:
// trace commands, cache lines with MESI state and per-way LRU rank.
package my_struct_package;

  localparam int SETS        = 16384;
  localparam int WAYS        = 8;
  localparam int SET_BITS    = $clog2(SETS);
  localparam int WAY_BITS    = $clog2(WAYS);
  localparam int TAG_BITS    = 12;
  localparam int OFFSET_BITS = 6;
  localparam int DATA_BITS   = 32;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef struct packed {
    logic [TAG_BITS-1:0]    tag;
    logic [SET_BITS-1:0]    set_index;
    logic [OFFSET_BITS-1:0] offset;
  } address_t;

  typedef struct packed {
    logic [3:0] n;
    address_t   address;
  } command_t;

  typedef struct packed {
    logic [TAG_BITS-1:0]  tag;
    mesi_t                mesi;
    logic [WAY_BITS-1:0]  lru;
    logic [DATA_BITS-1:0] data;
  } cache_line_t;

  typedef cache_line_t [WAYS-1:0] cache_set_t;

endpackage

// File: rtl/cache_controller_if.sv
// Bus bundle between the cache controller (master) and the trace reader /
// cache storage side (slave).
interface cache_controller_if;
  import my_struct_package::*;

  logic                cmd_valid;
  logic                cmd_ready;
  command_t            instruction;
  logic                snoop_shared;
  logic                read_enable;
  logic                write_enable;
  command_t            cache_request;
  cache_set_t [0:0]    cache_rd;
  cache_set_t [0:0]    cache_wr;
  logic                done;
  logic                hit;
  logic [WAY_BITS-1:0] victim_way;
  logic                evict_dirty;
  logic                writeback;
  logic [31:0]         hit_count;
  logic [31:0]         miss_count;

  modport master (
    input  cmd_valid, instruction, snoop_shared, cache_rd,
    output cmd_ready, read_enable, write_enable, cache_request, cache_wr,
           done, hit, victim_way, evict_dirty, writeback, hit_count, miss_count
  );

  modport slave (
    output cmd_valid, instruction, snoop_shared, cache_rd,
    input  cmd_ready, read_enable, write_enable, cache_request, cache_wr,
           done, hit, victim_way, evict_dirty, writeback, hit_count, miss_count
  );

endinterface

// File: rtl/cache_controller.sv
// Cache controller: takes one trace command at a time, reads the addressed
// set from storage, resolves hit/miss, applies MESI and LRU updates, writes
// the set back and reports the outcome with a one-cycle done pulse.
module cache_controller
  import my_struct_package::*;
(
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, READ, LOOKUP, UPDATE, CLEAR, PRINT, DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  command_t            cmd;
  logic                snoop;
  cache_set_t          set_q;
  cache_set_t          set_new;
  logic                hit_q;
  logic                evict_q;
  logic                wb_q;
  logic [WAY_BITS-1:0] victim_q;
  logic [31:0]         hit_count;
  logic [31:0]         miss_count;
  logic                counted;

  cache_set_t          look_set;
  logic                look_hit;
  logic                look_evict;
  logic                look_wb;
  logic [WAY_BITS-1:0] look_victim;
  logic                found_hit;
  logic                found_free;
  logic                fill;
  logic                touch;
  logic [WAY_BITS-1:0] hit_way;
  logic [WAY_BITS-1:0] free_way;
  logic [WAY_BITS-1:0] lru_way;
  logic [WAY_BITS-1:0] target;
  mesi_t               fill_mesi;

  assign counted        = (cmd.n <= 4'd2);
  assign bus.hit_count  = hit_count;
  assign bus.miss_count = miss_count;

  // State register; reset abandons whatever operation is in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and the storage/result strobes for the current state.
  always_comb begin
    state_next        = state;
    bus.cmd_ready     = 1'b0;
    bus.read_enable   = 1'b0;
    bus.write_enable  = 1'b0;
    bus.cache_request = '0;
    bus.cache_wr      = '0;
    bus.done          = 1'b0;
    bus.hit           = 1'b0;
    bus.victim_way    = '0;
    bus.evict_dirty   = 1'b0;
    bus.writeback     = 1'b0;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          case (bus.instruction.n)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: state_next = READ;
            4'd8:                         state_next = CLEAR;
            4'd9:                         state_next = PRINT;
            default:                      state_next = DONE;
          endcase
        end
      end
      READ: begin
        bus.read_enable   = 1'b1;
        bus.cache_request = cmd;
        state_next        = LOOKUP;
      end
      LOOKUP: state_next = UPDATE;
      UPDATE: begin
        bus.write_enable  = 1'b1;
        bus.cache_request = cmd;
        bus.cache_wr[0]   = set_new;
        state_next        = DONE;
      end
      CLEAR: begin
        bus.write_enable  = 1'b1;
        bus.cache_request = cmd;
        state_next        = DONE;
      end
      PRINT: begin
        bus.read_enable   = 1'b1;
        bus.cache_request = cmd;
        state_next        = DONE;
      end
      DONE: begin
        bus.done        = 1'b1;
        bus.hit         = hit_q;
        bus.victim_way  = victim_q;
        bus.evict_dirty = evict_q;
        bus.writeback   = wb_q;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Tag/MESI compare, victim choice and the modified copy of the set.
  always_comb begin
    look_set    = set_q;
    look_hit    = 1'b0;
    look_evict  = 1'b0;
    look_wb     = 1'b0;
    look_victim = '0;
    found_hit   = 1'b0;
    found_free  = 1'b0;
    fill        = 1'b0;
    touch       = 1'b0;
    hit_way     = '0;
    free_way    = '0;
    lru_way     = '0;
    target      = '0;
    fill_mesi   = MESI_I;

    for (int w = 0; w < WAYS; w++) begin
      if (set_q[w].mesi != MESI_I && set_q[w].tag == cmd.address.tag) begin
        found_hit = 1'b1;
        hit_way   = w[WAY_BITS-1:0];
      end
    end
    // Scan downwards so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (set_q[w].mesi == MESI_I) begin
        found_free = 1'b1;
        free_way   = w[WAY_BITS-1:0];
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (set_q[w].lru == '0) lru_way = w[WAY_BITS-1:0];
    end

    case (cmd.n)
      4'd0, 4'd2, 4'd1: begin
        touch = 1'b1;
        if (found_hit) begin
          target = hit_way;
          if (cmd.n == 4'd1) look_set[hit_way].mesi = MESI_M;
        end else begin
          fill   = 1'b1;
          target = found_free ? free_way : lru_way;
          if (cmd.n == 4'd1) fill_mesi = MESI_M;
          else if (snoop)    fill_mesi = MESI_S;
          else               fill_mesi = MESI_E;
        end
      end
      4'd3: begin
        if (found_hit) look_set[hit_way].mesi = MESI_I;
      end
      4'd4: begin
        if (found_hit) begin
          if (set_q[hit_way].mesi == MESI_M) begin
            look_set[hit_way].mesi = MESI_S;
            look_wb                = 1'b1;
          end else if (set_q[hit_way].mesi == MESI_E) begin
            look_set[hit_way].mesi = MESI_S;
          end
        end
      end
      default: ;
    endcase

    look_hit = found_hit;

    if (fill) begin
      look_set[target].tag  = cmd.address.tag;
      look_set[target].data = '0;
      look_set[target].mesi = fill_mesi;
      look_evict            = (set_q[target].mesi == MESI_M);
      look_victim           = target;
    end

    // Ways more recent than the touched one slide down; it becomes most recent.
    if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (set_q[w].lru > set_q[target].lru)
          look_set[w].lru = set_q[w].lru - WAY_BITS'(1);
      end
      look_set[target].lru = WAY_BITS'(WAYS - 1);
    end
  end

  // Command latch, set capture from storage and lookup result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd      <= '0;
      snoop    <= 1'b0;
      set_q    <= '0;
      set_new  <= '0;
      hit_q    <= 1'b0;
      victim_q <= '0;
      evict_q  <= 1'b0;
      wb_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cmd      <= bus.instruction;
            snoop    <= bus.snoop_shared;
            hit_q    <= 1'b0;
            victim_q <= '0;
            evict_q  <= 1'b0;
            wb_q     <= 1'b0;
          end
        end
        READ: set_q <= bus.cache_rd[0];
        LOOKUP: begin
          set_new  <= look_set;
          hit_q    <= look_hit;
          victim_q <= look_victim;
          evict_q  <= look_evict;
          wb_q     <= look_wb;
        end
        default: ;
      endcase
    end
  end

  // Hit/miss statistics for read, write and fetch; cleared by the clear command.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == CLEAR) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == DONE && counted) begin
      if (hit_q) hit_count  <= hit_count + 32'd1;
      else       miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Initiator side of the L1 cache storage interface.
- Accepts one trace command at a time (command_t from my_struct_package), reads the addressed set from storage, and resolves hit or miss by tag and MESI compare.
- Applies LRU and MESI updates, writes the modified set back to storage, and keeps hit and miss statistics.
- Sits between the trace-file reader and the cache storage array.

Parameters:
- sets, 16384, number of sets (set_index width = 14)
- ways, 8, associativity (LRU and way-index width = 3)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  instruction is valid
- cmd_ready  output  1  controller idle, can accept
- instruction  input  command_t  trace op n (4b) plus address {tag 12, set_index 14, offset 6}
- snoop_shared  input  1  on a read/fetch miss, another cache holds the line
- read_enable  output  1  storage read strobe
- write_enable  output  1  storage write strobe
- cache_request  output  command_t  command forwarded to storage
- cache_rd  input  cache_line_t[1][ways]  set returned by storage
- cache_wr  output  cache_line_t[1][ways]  set to be written to storage
- done  output  1  one-cycle completion pulse
- hit  output  1  valid with done
- victim_way  output  3  way used on a fill; valid with done
- evict_dirty  output  1  fill replaced an M line; valid with done
- writeback  output  1  snoop (n=4) hit an M line; valid with done
- hit_count  output  32  hits for n=0/1/2; wraps
- miss_count  output  32  misses for n=0/1/2; wraps

Behaviour:
- Reset values:
  - All outputs 0; cmd_ready=1; FSM in IDLE; counters 0.
  - rst during any state aborts the op immediately; no write_enable is issued afterwards.
- FSM states: IDLE, READ, LOOKUP, UPDATE, CLEAR, PRINT, DONE.
- IDLE:
  - cmd_ready=1; the command is latched when cmd_valid&&cmd_ready.
  - n in 0..4 -> READ; n=8 -> CLEAR; n=9 -> PRINT; any other n -> DONE with hit=0 and no storage access.
- READ (1 cycle):
  - read_enable=1 and cache_request=latched command.
  - cache_rd is sampled into an internal set register at the end of the cycle.
- LOOKUP (1 cycle):
  - Way w hits when MESI!=I and tag==address.tag; at most one way hits.
  - On a miss, the victim is the lowest-index way with MESI==I; if none, the way with LRU==0.
- UPDATE (1 cycle): write_enable=1, cache_request=latched command, cache_wr=modified set. Never assert read_enable and write_enable together.
- DONE (1 cycle): done=1; hit, victim_way, evict_dirty and writeback are valid, then return to IDLE. Total latency for n=0..4 is accept edge + 4 cycles to the done pulse.
- LRU convention: 0 = least recent, ways-1 = most recent. On a touch of way w with old value L:
  - Every way with LRU>L decrements by 1.
  - Way w is set to ways-1.
  - The LRU fields remain a permutation of 0..ways-1.
- Commands n=0 (read) and n=2 (fetch):
  - Hit: MESI unchanged, touch.
  - Miss: fill the victim with tag=address.tag, data=0, MESI=S if snoop_shared else E; touch; evict_dirty=1 if the victim was M.
- Command n=1 (write):
  - Hit: MESI becomes M (from M, E or S), touch.
  - Miss: fill as above with MESI=M.
- Command n=3 (invalidate): hit sets MESI=I with LRU unchanged; miss leaves the set unmodified.
- Command n=4 (snoop read):
  - Hit in M becomes S with writeback=1; E becomes S; S unchanged; LRU unchanged.
  - Miss leaves the set unmodified.
- Counting:
  - Counts update in DONE, for n=0/1/2 only: hit_count++ on a hit, miss_count++ on a miss.
  - n=3/4 never count.
- CLEAR (1 cycle): write_enable=1 with cache_request.n=8; both counters cleared; -> DONE.
- PRINT (1 cycle): read_enable=1 with cache_request.n=9; no state change; -> DONE.
- cmd_valid is ignored outside IDLE; commands are never queued.

Test Plan:
- Reset followed by n=8 -> write_enable pulse with n=8, counters 0, done pulse one cycle later.
- n=0 to address 0x0000_0040 (set 1, tag 0) on an empty set -> miss, victim_way=0, way0 E with LRU=7, others' LRU decremented, miss_count=1, done at accept+4.
- Repeat the same n=0, then n=1 to the same address -> both hits, way0 E then M, hit_count=2.
- Nine distinct-tag n=1 writes to one set -> ways 0..7 filled M; ninth evicts the LRU==0 way (way0) with evict_dirty=1, and all LRU fields stay a permutation.
- n=4 on an M line -> writeback=1, MESI=S; then n=3 to the same line -> MESI=I, counters unchanged.
- rst asserted during LOOKUP -> next cycle cmd_ready=1, write_enable never asserts, counters 0.
